// File: rtl/riscv_rf_pkg.sv
// Shared register-file types and defaults for the pipelined core.
package riscv_rf_pkg;
  localparam int XLEN_DEF  = 64;
  localparam int NREGS_DEF = 32;
  localparam int ZERO_ADDR = 0;

  typedef logic [4:0]  reg_addr_t;
  typedef logic [63:0] xword_t;
endpackage

// File: rtl/regfile_wr_arb.sv
// Write-port arbiter: does any enabled write port target q_addr, and which
// one wins. The highest-index port wins. Writes to the hardwired zero
// register are dropped, so they never hit.
module regfile_wr_arb
  import riscv_rf_pkg::*;
#(
  parameter int NWR      = 2,
  parameter int AW       = 5,
  parameter int ZERO_REG = 1,
  parameter int IW       = (NWR > 1) ? $clog2(NWR) : 1
) (
  input  logic [NWR-1:0]         en,
  input  logic [NWR-1:0][AW-1:0] addr,
  input  logic [AW-1:0]          q_addr,
  output logic                   hit,
  output logic [IW-1:0]          idx
);

  // Scan low to high so the last match (highest port) sticks.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    if (!(ZERO_REG != 0 && q_addr == AW'(ZERO_ADDR))) begin
      for (int i = 0; i < NWR; i++) begin
        if (en[i] && addr[i] == q_addr) begin
          hit = 1'b1;
          idx = IW'(i);
        end
      end
    end
  end

endmodule

// File: rtl/regfile_mp_sb.sv
// Multi-port integer register file with write-to-read bypass and a busy
// scoreboard for decode-stage hazard detection.
module regfile_mp_sb
  import riscv_rf_pkg::*;
#(
  parameter int XLEN     = XLEN_DEF,
  parameter int NREGS    = NREGS_DEF,
  parameter int NRD      = 2,
  parameter int NWR      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NRD-1:0][$clog2(NREGS)-1:0] rd_addr,
  output logic [NRD-1:0][XLEN-1:0] rd_data,
  output logic [NRD-1:0]           rd_busy,
  input  logic [NWR-1:0]           wr_en,
  input  logic [NWR-1:0][$clog2(NREGS)-1:0] wr_addr,
  input  logic [NWR-1:0][XLEN-1:0] wr_data,
  input  logic                     iss_valid,
  input  logic [$clog2(NREGS)-1:0] iss_rd,
  output logic [NREGS-1:0]         busy_vec
);

  localparam int AW = $clog2(NREGS);
  localparam int IW = (NWR > 1) ? $clog2(NWR) : 1;

  logic [NREGS-1:0][XLEN-1:0] mem;
  logic [NREGS-1:0]           busy, busy_nxt;
  logic [NREGS-1:0]           whit;
  logic [NREGS-1:0][XLEN-1:0] wsel;

  // Mux of write data by winning port index (no variable array index).
  function automatic logic [XLEN-1:0] pick(input logic [IW-1:0] k,
                                           input logic [NWR-1:0][XLEN-1:0] d);
    pick = '0;
    for (int i = 0; i < NWR; i++)
      if (k == IW'(i)) pick = d[i];
  endfunction

  // Per-register write resolution: one arbiter per storage entry.
  for (genvar r = 0; r < NREGS; r++) begin : g_wr
    logic [IW-1:0] widx;
    regfile_wr_arb #(.NWR(NWR), .AW(AW), .ZERO_REG(ZERO_REG), .IW(IW)) u_warb (
      .en(wr_en), .addr(wr_addr), .q_addr(AW'(r)), .hit(whit[r]), .idx(widx)
    );
    assign wsel[r] = pick(widx, wr_data);
  end

  // Scoreboard next state: issue sets, write clears, set beats clear.
  always_comb begin
    busy_nxt = busy;
    for (int r = 0; r < NREGS; r++) begin
      if (whit[r]) busy_nxt[r] = 1'b0;
      if (iss_valid && iss_rd == AW'(r) && !(ZERO_REG != 0 && r == ZERO_ADDR))
        busy_nxt[r] = 1'b1;
    end
  end

  // Storage and scoreboard state; reset drops any same-cycle write/issue.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem  <= '0;
      busy <= '0;
    end else begin
      for (int r = 0; r < NREGS; r++)
        if (whit[r]) mem[r] <= wsel[r];
      busy <= busy_nxt;
    end
  end

  assign busy_vec = busy;

  // Read ports: zero register, then bypass, then stored contents.
  for (genvar j = 0; j < NRD; j++) begin : g_rd
    logic          rhit;
    logic [IW-1:0] ridx;
    logic [XLEN-1:0] d;
    logic            b;
    logic            is_zero;

    regfile_wr_arb #(.NWR(NWR), .AW(AW), .ZERO_REG(ZERO_REG), .IW(IW)) u_rarb (
      .en(wr_en), .addr(wr_addr), .q_addr(rd_addr[j]), .hit(rhit), .idx(ridx)
    );

    assign is_zero = (ZERO_REG != 0) && (rd_addr[j] == AW'(ZERO_ADDR));

    // Combinational read with bypass; a bypassed write masks busy.
    always_comb begin
      d = mem[rd_addr[j]];
      b = busy[rd_addr[j]];
      if (reset || is_zero) begin
        d = '0;
        b = 1'b0;
      end else if (BYPASS != 0 && rhit) begin
        d = pick(ridx, wr_data);
        b = 1'b0;
      end
    end

    assign rd_data[j] = d;
    assign rd_busy[j] = b;
  end

endmodule

// File: tb/tb_regfile_mp_sb.sv
// Directed bench: default config, BYPASS=0 twin, and a small 32x16 3R1W config.
module tb_regfile_mp_sb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  // Shared stimulus for the two 64-bit, 32-entry instances.
  logic [1:0][4:0]  rd_addr;
  logic [1:0][63:0] rd_data_b, rd_data_n;
  logic [1:0]       rd_busy_b, rd_busy_n;
  logic [1:0]       wr_en;
  logic [1:0][4:0]  wr_addr;
  logic [1:0][63:0] wr_data;
  logic             iss_valid;
  logic [4:0]       iss_rd;
  logic [31:0]      busy_vec_b, busy_vec_n;

  // Small configuration.
  logic [2:0][3:0]  s_rd_addr;
  logic [2:0][31:0] s_rd_data;
  logic [2:0]       s_rd_busy;
  logic [0:0]       s_wr_en;
  logic [0:0][3:0]  s_wr_addr;
  logic [0:0][31:0] s_wr_data;
  logic             s_iss_valid;
  logic [3:0]       s_iss_rd;
  logic [15:0]      s_busy_vec;

  int total = 0;
  int bad   = 0;

  regfile_mp_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_b),
    .rd_busy(rd_busy_b), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec_b)
  );

  regfile_mp_sb #(.BYPASS(0)) u_nobyp (
    .clk(clk), .reset(reset), .rd_addr(rd_addr), .rd_data(rd_data_n),
    .rd_busy(rd_busy_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .busy_vec(busy_vec_n)
  );

  regfile_mp_sb #(.XLEN(32), .NREGS(16), .NRD(3), .NWR(1)) u_small (
    .clk(clk), .reset(reset), .rd_addr(s_rd_addr), .rd_data(s_rd_data),
    .rd_busy(s_rd_busy), .wr_en(s_wr_en), .wr_addr(s_wr_addr), .wr_data(s_wr_data),
    .iss_valid(s_iss_valid), .iss_rd(s_iss_rd), .busy_vec(s_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en     = '0;
    iss_valid = 1'b0;
    s_wr_en   = '0;
    s_iss_valid = 1'b0;
  endtask

  task automatic wr(input int p, input logic [4:0] a, input logic [63:0] d);
    wr_en[p]   = 1'b1;
    wr_addr[p] = a;
    wr_data[p] = d;
  endtask

  initial begin
    reset = 1'b1;
    rd_addr = '0; wr_addr = '0; wr_data = '0; iss_rd = '0;
    s_rd_addr = '0; s_wr_addr = '0; s_wr_data = '0; s_iss_rd = '0;
    idle();
    tick();
    rd_addr[0] = 5'd5;
    wr(0, 5'd5, 64'hFFFF);
    #1;
    chk("rst_rd_data", rd_data_b[0], 64'h0);
    chk("rst_rd_busy", {63'h0, rd_busy_b[0]}, 64'h0);
    tick();
    chk("rst_busy_vec", {32'h0, busy_vec_b}, 64'h0);
    reset = 1'b0;
    idle();

    // Reset clears stored data.
    wr(0, 5'd5, 64'hDEAD);
    iss_valid = 1'b1; iss_rd = 5'd5;
    tick();
    idle();
    #1;
    chk("pre_rst_x5", rd_data_b[0], 64'hDEAD);
    reset = 1'b1;
    wr(1, 5'd12, 64'h77);
    tick();
    reset = 1'b0;
    idle();
    #1;
    chk("post_rst_x5", rd_data_b[0], 64'h0);
    chk("post_rst_busy", {32'h0, busy_vec_b}, 64'h0);
    rd_addr[1] = 5'd12;
    #1;
    chk("rst_drops_wr", rd_data_b[1], 64'h0);

    // Zero register ignores writes and issue.
    wr(0, 5'd0, 64'h1234);
    iss_valid = 1'b1; iss_rd = 5'd0;
    rd_addr[0] = 5'd0;
    #1;
    chk("x0_no_bypass", rd_data_b[0], 64'h0);
    tick();
    idle();
    #1;
    chk("x0_read", rd_data_b[0], 64'h0);
    chk("x0_busy_vec", {63'h0, busy_vec_b[0]}, 64'h0);
    chk("x0_rd_busy", {63'h0, rd_busy_b[0]}, 64'h0);

    // Bypass vs stored read; busy masked only with bypass.
    wr(0, 5'd7, 64'h1111);
    tick();
    idle();
    iss_valid = 1'b1; iss_rd = 5'd7;
    tick();
    idle();
    wr(0, 5'd7, 64'hCAFE);
    rd_addr[1] = 5'd7;
    #1;
    chk("byp_data", rd_data_b[1], 64'hCAFE);
    chk("byp_busy", {63'h0, rd_busy_b[1]}, 64'h0);
    chk("nobyp_data", rd_data_n[1], 64'h1111);
    chk("nobyp_busy", {63'h0, rd_busy_n[1]}, 64'h1);
    tick();
    idle();
    #1;
    chk("byp_stored", rd_data_b[1], 64'hCAFE);
    chk("nobyp_stored", rd_data_n[1], 64'hCAFE);
    chk("nobyp_cleared", {63'h0, rd_busy_n[1]}, 64'h0);

    // Same-address write conflict: port 1 wins.
    wr(0, 5'd9, 64'h11);
    wr(1, 5'd9, 64'h22);
    rd_addr[0] = 5'd9;
    #1;
    chk("conf_byp", rd_data_b[0], 64'h22);
    tick();
    idle();
    #1;
    chk("conf_store_b", rd_data_b[0], 64'h22);
    chk("conf_store_n", rd_data_n[0], 64'h22);

    // Two different addresses in one cycle both land.
    wr(0, 5'd10, 64'hA0);
    wr(1, 5'd11, 64'hB1);
    tick();
    idle();
    rd_addr[0] = 5'd10; rd_addr[1] = 5'd11;
    #1;
    chk("dual_wr_p0", rd_data_n[0], 64'hA0);
    chk("dual_wr_p1", rd_data_n[1], 64'hB1);

    // Scoreboard timing and set-beats-clear.
    rd_addr[0] = 5'd3;
    iss_valid = 1'b1; iss_rd = 5'd3;
    tick();
    idle();
    #1;
    chk("sb_t1", {63'h0, busy_vec_b[3]}, 64'h1);
    chk("sb_t1_rd", {63'h0, rd_busy_b[0]}, 64'h1);
    tick();
    chk("sb_t2", {63'h0, busy_vec_b[3]}, 64'h1);
    iss_valid = 1'b1; iss_rd = 5'd3;
    wr(0, 5'd3, 64'h33);
    tick();
    idle();
    chk("sb_set_wins", {63'h0, busy_vec_b[3]}, 64'h1);
    wr(1, 5'd3, 64'h44);
    tick();
    idle();
    #1;
    chk("sb_t4_clear", {63'h0, busy_vec_b[3]}, 64'h0);
    chk("sb_t4_data", rd_data_b[0], 64'h44);
    chk("sb_only_x3", {32'h0, busy_vec_n}, 64'h0);

    // Small configuration: fill all 16 entries, read back on three ports.
    for (int i = 0; i < 16; i++) begin
      s_wr_en[0]   = 1'b1;
      s_wr_addr[0] = 4'(i);
      s_wr_data[0] = 32'hA5A5_0000 + 32'(i);
      tick();
    end
    idle();
    for (int i = 0; i < 16; i++) begin
      int a1, a2;
      logic [63:0] e0, e1, e2;
      a1 = (i + 1) % 16;
      a2 = (i + 5) % 16;
      s_rd_addr[0] = 4'(i);
      s_rd_addr[1] = 4'(a1);
      s_rd_addr[2] = 4'(a2);
      e0 = (i  == 0) ? 64'h0 : 64'hA5A5_0000 + 64'(i);
      e1 = (a1 == 0) ? 64'h0 : 64'hA5A5_0000 + 64'(a1);
      e2 = (a2 == 0) ? 64'h0 : 64'hA5A5_0000 + 64'(a2);
      #1;
      chk("sw_p0", {32'h0, s_rd_data[0]}, e0);
      chk("sw_p1", {32'h0, s_rd_data[1]}, e1);
      chk("sw_p2", {32'h0, s_rd_data[2]}, e2);
    end
    chk("sw_busy", {48'h0, s_busy_vec}, 64'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/regfile_mp_sb.md
Name: regfile_mp_sb

Overview:
- Parametrised multi-port integer register file for the pipelined RISC-V core. Successor to the single-write, two-read register file.
- Adds configurable width, depth and port counts, a hardwired-zero register, posedge writes with write-to-read bypass, and an integrated busy scoreboard for hazard detection in decode.
- Sits between decode (read and issue side) and writeback (write side).

Parameters:
- XLEN, 64, data width in bits
- NREGS, 32, number of architectural registers (power of two, >=2)
- NRD, 2, number of read ports
- NWR, 2, number of write ports
- BYPASS, 1, 1 = same-cycle write data is forwarded to read ports; 0 = reads see only stored contents
- ZERO_REG, 1, 1 = register 0 reads 0, ignores writes and is never busy
- AW, $clog2(NREGS), derived address width (localparam)

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- rd_addr  in  NRD x AW  read addresses
- rd_data  out  NRD x XLEN  read data, combinational
- rd_busy  out  NRD  scoreboard bit of the addressed register
- wr_en  in  NWR  write enables
- wr_addr  in  NWR x AW  write addresses
- wr_data  in  NWR x XLEN  write data
- iss_valid  in  1  issue of an instruction that writes a register
- iss_rd  in  AW  destination register of the issued instruction
- busy_vec  out  NREGS  full scoreboard, for debug and stall logic

Behaviour:
- Reset: reset is synchronous and active-high. While reset is high at a posedge, all registers clear to 0 and all busy bits clear to 0.
- Outputs during reset: while reset is asserted, rd_data = 0 and rd_busy = 0, combinationally. busy_vec reflects the cleared state one cycle after the first reset edge.
- Write: on posedge with wr_en[i]=1, mem[wr_addr[i]] <= wr_data[i]. Write latency is 1 cycle.
- Write conflict: if several ports write the same address in one cycle, the highest port index wins. This holds for both storage and bypass.
- Zero register: when ZERO_REG=1, writes to address 0 are dropped. Reads of address 0 return 0, rd_busy = 0, busy_vec[0] = 0, and issue to address 0 is ignored.
- Read: rd_data[j] is mem[rd_addr[j]], with zero-cycle latency.
- Bypass: when BYPASS=1 and some wr_en[i]=1 with wr_addr[i]==rd_addr[j] (not a dropped zero write), rd_data[j] returns the winning wr_data in the same cycle.
- Scoreboard: each register has one busy bit.
  - On posedge, iss_valid=1 sets busy[iss_rd].
  - Any wr_en[i]=1 clears busy[wr_addr[i]].
  - If set and clear hit the same register in one cycle, set wins, because a newer producer is now in flight.
- Busy output: rd_busy[j] = busy[rd_addr[j]], masked off when a bypassed write to that address is active in the same cycle (BYPASS=1 only). With BYPASS=0, rd_busy shows the stored bit.
- Independence: read ports are fully independent; any number may address the same register.
- Addresses: all addresses are in range by construction. No out-of-range handling is required when NREGS = 2^AW.
- Reset mid-operation: reset overrides all writes and issues in that cycle. No write is retained.
- No initial-block contents. The only way to preload is through reset followed by writes.

Decomposition:
- Shared package riscv_rf_pkg holds:
  - default constants XLEN_DEF=64 and NREGS_DEF=32
  - typedef reg_addr_t (logic [4:0])
  - typedef xword_t (logic [63:0])
  - localparam ZERO_ADDR = 0
- One natural sub-module, regfile_wr_arb: given the NWR enables and addresses plus one query address, it returns hit and winning port index. It is instantiated once per read port for bypass, and reused for storage conflict resolution.
- Scoreboard stays inline.

Test Plan:
- Reset clear: write 0xDEAD to x5, assert reset for 1 cycle, then read x5 -> rd_data=0, busy_vec=0.
- Zero register: write 0x1234 to x0 on port 0 and issue x0 -> next cycle x0 reads 0 and busy_vec[0]=0.
- Bypass: same cycle, wr_en[0]=1 with addr x7 = 0xCAFE, and rd_addr[1]=x7 -> rd_data[1]=0xCAFE combinationally, rd_busy[1]=0. Repeat with BYPASS=0 -> old value returned.
- Write conflict: port0 writes x9=0x11 and port1 writes x9=0x22 in the same cycle -> bypass and later reads both return 0x22.
- Scoreboard: issue x3 in cycle t -> busy[3]=1 from t+1. Issue x3 again while writing x3 in cycle t+2 -> busy[3] stays 1. Write x3 at t+3 -> busy[3]=0 at t+4.
- Parameter sweep: XLEN=32, NREGS=16, NRD=3, NWR=1 -> write and read all 16 registers with pattern 0xA5A5_0000+i, all read back correctly on all three ports.
